// File: rtl/hamming_dist_acc.sv
// rtl/hamming_dist_acc.sv - streaming per-class Hamming distance accumulator
//
// Purpose:
//   Accepts a query hypervector as NCHUNK beats of CHUNK_W bits, each beat
//   paired with the matching chunk of every class hypervector. Per class it
//   XORs, popcounts and accumulates. After the last chunk it presents CLS_NUM
//   distances on a valid/ready output to the downstream arg-min stage.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   input chunk valid
//   in_ready   out  chunk accepted when in_valid & in_ready
//   in_query   in   query chunk
//   in_cls     in   class chunks, same chunk index as in_query
//   chunk_idx  out  index of next expected chunk (class-memory read address)
//   out_valid  out  distances valid
//   out_ready  in   downstream accepts when out_valid & out_ready
//   out_dist   out  Hamming distance per class, 0..DIM
//
// Build option:
//   HDC_DIST_PIPE_EN - register popcounts before accumulation (latency 2).

module hamming_dist_acc #(
  parameter int DIM      = 1024,
  parameter int CLS_NUM  = 16,
  parameter int CHUNK_W  = 64,
  localparam int NCHUNK  = DIM / CHUNK_W,
  localparam int DW      = $clog2(DIM) + 1,
  localparam int IW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHUNK_W-1:0]               in_query,
  input  logic [CLS_NUM-1:0][CHUNK_W-1:0]  in_cls,
  output logic [IW-1:0]                    chunk_idx,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CLS_NUM-1:0][DW-1:0]       out_dist
);

  localparam int PCW = $clog2(CHUNK_W) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [CLS_NUM-1:0][DW-1:0]  acc;
  logic [CLS_NUM-1:0][DW-1:0]  sum;
  logic [CLS_NUM-1:0][PCW-1:0] pc;
  logic [CLS_NUM-1:0][PCW-1:0] add_pc;

  logic accept;
  logic last_chunk;
  logic drain;      // final popcount still sitting in the pipe register
  logic fold_en;    // add add_pc into the accumulators this cycle
  logic fold_last;  // this fold completes the vector

  function automatic logic [PCW-1:0] popcount(input logic [CHUNK_W-1:0] v);
    logic [PCW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      cnt = cnt + PCW'(v[i]);
    end
    return cnt;
  endfunction

  always_comb begin
    for (int c = 0; c < CLS_NUM; c++) begin
      pc[c] = popcount(in_query ^ in_cls[c]);
    end
  end

`ifdef HDC_DIST_PIPE_EN
  logic                        pipe_valid;
  logic                        pipe_last;
  logic [CLS_NUM-1:0][PCW-1:0] pipe_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_last  <= 1'b0;
      pipe_pc    <= '0;
    end else begin
      pipe_valid <= accept;
      pipe_last  <= accept && last_chunk;
      if (accept) begin
        pipe_pc <= pc;
      end
    end
  end

  assign drain  = pipe_valid && pipe_last;
  assign add_pc = pipe_pc;
`else
  assign drain  = 1'b0;
  assign add_pc = pc;
`endif

  // Control: handshake, fold enables and next state in one place so that
  // accept is derived from in_ready without a combinational round trip.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    fold_en    = 1'b0;
    fold_last  = 1'b0;
    last_chunk = (chunk_idx == LAST_IDX);
    case (state)
      ACCUM: begin
        in_ready = !rst && !drain;
        accept   = in_valid && in_ready;
`ifdef HDC_DIST_PIPE_EN
        fold_en   = pipe_valid;
        fold_last = drain;
`else
        fold_en   = accept;
        fold_last = accept && last_chunk;
`endif
        if (fold_last) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // The running sum never exceeds DIM, which DW holds exactly.
  always_comb begin
    for (int c = 0; c < CLS_NUM; c++) begin
      sum[c] = acc[c] + DW'(add_pc[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      out_dist <= '0;
    end else if (fold_en) begin
      if (fold_last) begin
        out_dist <= sum;
        acc      <= '0;
      end else begin
        acc <= sum;
      end
    end
  end

  // The read address wraps at accept time, so in the pipelined build the
  // class memory already points at chunk 0 while the last popcount drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_idx <= '0;
    end else if (accept) begin
      if (last_chunk) begin
        chunk_idx <= '0;
      end else begin
        chunk_idx <= chunk_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hamming_dist_acc.sv
// tb/tb_hamming_dist_acc.sv - self-checking bench for hamming_dist_acc

module tb_hamming_dist_acc;

  localparam int DIM = 1024;
  localparam int CLS = 16;
  localparam int CW  = 64;
  localparam int NCH = 16;
  localparam int DW  = 11;
  localparam int IW  = 4;
  localparam int NV  = 8;
`ifdef HDC_DIST_PIPE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  // pat: 0 low-k-bits (T1), 1 ones-vs-zero (T2), 2 query equals class 5, 3 random
  // bubble: 0 back-to-back, 1 toggle, 2 random
  typedef struct packed {
    logic [3:0]                 pat;
    logic [1:0]                 bubble;
    logic [3:0]                 hold;
    logic [CLS-1:0][DW-1:0]     exp_d;
  } vec_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [CW-1:0]             in_query;
  logic [CLS-1:0][CW-1:0]    in_cls;
  logic [IW-1:0]             chunk_idx;
  logic                      out_valid;
  logic                      out_ready;
  logic [CLS-1:0][DW-1:0]    out_dist;

  int checks = 0;
  int failures = 0;

  vec_t          tbl [NV];
  logic [CW-1:0] rq  [NV][NCH];
  logic [CW-1:0] rc  [NV][NCH][CLS];

  hamming_dist_acc #(.DIM(DIM), .CLS_NUM(CLS), .CHUNK_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_query(in_query), .in_cls(in_cls), .chunk_idx(chunk_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Reference: Hamming distance of the whole hypervector, chunk by chunk.
  function automatic int ref_dist(input int v, input int c);
    int d = 0;
    for (int k = 0; k < NCH; k++) d += $countones(rq[v][k] ^ rc[v][k][c]);
    return d;
  endfunction

  task automatic fill(input int v, input int pat, input int bub, input int hold);
    logic [CW-1:0] one = 64'd1;
    tbl[v].pat = 4'(pat);
    tbl[v].bubble = 2'(bub);
    tbl[v].hold = 4'(hold);
    for (int k = 0; k < NCH; k++) begin
      case (pat)
        0: begin
          rq[v][k] = '0;
          for (int c = 0; c < CLS; c++) rc[v][k][c] = (one << c) - one;
        end
        1: begin
          rq[v][k] = '1;
          for (int c = 0; c < CLS; c++) rc[v][k][c] = '0;
        end
        default: begin
          rq[v][k] = rnd64();
          for (int c = 0; c < CLS; c++) rc[v][k][c] = rnd64();
          if (pat == 2) rc[v][k][5] = rq[v][k];
        end
      endcase
    end
    for (int c = 0; c < CLS; c++) begin
      case (pat)
        0:       tbl[v].exp_d[c] = DW'(16 * c);
        1:       tbl[v].exp_d[c] = DW'(DIM);
        default: tbl[v].exp_d[c] = DW'(ref_dist(v, c));
      endcase
    end
    if (pat == 2) tbl[v].exp_d[5] = '0;
  endtask

  task automatic feed(input int v, input int nb, input int bub);
    int k = 0;
    int cyc = 0;
    bit acc_now;
    while (k < nb && cyc < 400) begin
      in_query = rq[v][k];
      for (int c = 0; c < CLS; c++) in_cls[c] = rc[v][k][c];
      case (bub)
        0: in_valid = 1'b1;
        1: in_valid = ((cyc % 2) == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (acc_now) chk("chunk_idx_at_accept", int'(chunk_idx), k);
      @(posedge clk);
      #1;
      if (acc_now) k++;
      cyc++;
    end
    in_valid = 1'b0;
    if (k < nb) chk("feed_timeout_beats", k, nb);
  endtask

  task automatic collect(input int v);
    int lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, EXP_LAT);
    chk("chunk_idx_after_last", int'(chunk_idx), 0);
    chk("in_ready_in_hold", int'(in_ready), 0);
    for (int c = 0; c < CLS; c++) chk($sformatf("dist_v%0d_c%0d", v, c), int'(out_dist[c]), int'(tbl[v].exp_d[c]));
    for (int h = 0; h < int'(tbl[v].hold); h++) begin
      in_valid = 1'b1;
      in_query = rnd64();
      for (int c = 0; c < CLS; c++) in_cls[c] = rnd64();
      @(posedge clk);
      #1;
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_chunk_idx", int'(chunk_idx), 0);
      chk("hold_dist_c7", int'(out_dist[7]), int'(tbl[v].exp_d[7]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_handshake", int'(out_valid), 0);
    chk("in_ready_after_handshake", int'(in_ready), 1);
    chk("dist_kept_c15", int'(out_dist[15]), int'(tbl[v].exp_d[15]));
  endtask

  initial begin
    int w;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_query = '0;
    in_cls = '0;

    fill(0, 0, 0, 0);
    fill(1, 1, 0, 0);
    fill(2, 2, 0, 0);
    fill(3, 0, 0, 5);
    fill(4, 0, 1, 0);
    fill(5, 3, 2, 2);
    fill(6, 3, 0, 0);
    fill(7, 1, 0, 0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_chunk_idx", int'(chunk_idx), 0);
    chk("rst_dist_c9", int'(out_dist[9]), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    for (int v = 0; v < NV - 1; v++) begin
      feed(v, NCH, int'(tbl[v].bubble));
      collect(v);
    end

    // Reset mid-vector, then a full all-ones vector must show no carry-over.
    feed(0, 7, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("midrst_chunk_idx", int'(chunk_idx), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_dist_c3", int'(out_dist[3]), 0);
    feed(7, NCH, 0);
    collect(7);

    // Reset while a result is pending drops it.
    feed(6, NCH, 0);
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("pre_hold_rst_out_valid", int'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("hold_rst_out_valid", int'(out_valid), 0);
    chk("hold_rst_dist_c1", int'(out_dist[1]), 0);
    chk("hold_rst_in_ready", int'(in_ready), 1);
    feed(0, NCH, 0);
    collect(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
